// File: rtl/mant_norm23_if.sv
// rtl/mant_norm23_if.sv - handshake bundle between csl23bit output and mant_norm23
interface mant_norm23_if #(
    parameter int W  = 23,
    parameter int AW = 6
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_sum;
    logic          in_cout;
    logic          in_sub;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_mant;
    logic [AW-1:0] out_adj;
    logic          out_sign;
    logic          out_zero;
    logic          out_sticky;

    // Upstream adder plus downstream consumer, seen from the testbench side
    modport master (
        output in_valid, in_sum, in_cout, in_sub, out_ready,
        input  in_ready, out_valid, out_mant, out_adj, out_sign, out_zero, out_sticky
    );

    // Normalizer side
    modport slave (
        input  in_valid, in_sum, in_cout, in_sub, out_ready,
        output in_ready, out_valid, out_mant, out_adj, out_sign, out_zero, out_sticky
    );
endinterface

// File: rtl/mant_norm23.sv
// rtl/mant_norm23.sv - iterative one-bit-per-cycle post-normalizer for the 23-bit adder
module mant_norm23 #(
    parameter int W  = 23,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    mant_norm23_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    logic          in_ready_r;
    logic          out_valid_r;
    logic [W-1:0]  mant_reg;
    logic [AW-1:0] adj_reg;
    logic          sign_reg;
    logic          zero_reg;
    logic          sticky_reg;

    // Sequencer: preprocess on accept, shift left until MSB set or zero, hold until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            mant_reg    <= '0;
            adj_reg     <= '0;
            sign_reg    <= 1'b0;
            zero_reg    <= 1'b0;
            sticky_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        adj_reg    <= '0;
                        sign_reg   <= 1'b0;
                        zero_reg   <= 1'b0;
                        sticky_reg <= 1'b0;
                        if (!bus.in_sub) begin
                            if (bus.in_cout) begin
                                // Carry out of an add: shift right once, keep the lost bit
                                mant_reg   <= {1'b1, bus.in_sum[W-1:1]};
                                adj_reg    <= AW'(1);
                                sticky_reg <= bus.in_sum[0];
                            end else begin
                                mant_reg <= bus.in_sum;
                            end
                        end else if (bus.in_cout) begin
                            mant_reg <= bus.in_sum;
                        end else begin
                            // No carry on subtract means A<B: take the two's-complement magnitude
                            mant_reg <= (~bus.in_sum) + W'(1);
                            sign_reg <= 1'b1;
                        end
                        in_ready_r <= 1'b0;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (mant_reg == '0) begin
                        zero_reg    <= 1'b1;
                        sign_reg    <= 1'b0;
                        adj_reg     <= '0;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end else if (mant_reg[W-1]) begin
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end else begin
                        mant_reg <= {mant_reg[W-2:0], 1'b0};
                        adj_reg  <= adj_reg - AW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_mant   = mant_reg;
    assign bus.out_adj    = adj_reg;
    assign bus.out_sign   = sign_reg;
    assign bus.out_zero   = zero_reg;
    assign bus.out_sticky = sticky_reg;
endmodule

// File: tb/tb_mant_norm23.sv
// tb/tb_mant_norm23.sv - scoreboard bench for mant_norm23
module tb_mant_norm23;
    localparam int W  = 23;
    localparam int AW = 6;

    typedef struct {
        logic [W-1:0]  mant;
        logic [AW-1:0] adj;
        logic          sign;
        logic          zero;
        logic          sticky;
        int            lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    mant_norm23_if #(.W(W), .AW(AW)) bus ();

    mant_norm23 #(.W(W), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Reference: value-level normalization by locating the leading one
    function automatic exp_t model(input logic [W-1:0] sum, input logic cout, input logic sub);
        exp_t e;
        logic [W:0]   wide;
        logic [W-1:0] mag;
        int           p;
        e.sticky = 1'b0;
        e.sign   = 1'b0;
        e.zero   = 1'b0;
        if (!sub && cout) begin
            wide   = {cout, sum};
            e.mant = wide[W:1];
            e.adj  = AW'(1);
            e.sticky = sum[0];
            e.lat  = 1;
            return e;
        end
        wide = (sub && !cout) ? ((W+1)'(1) << W) - {1'b0, sum} : {1'b0, sum};
        mag  = wide[W-1:0];
        e.sign = sub && !cout;
        if (mag == '0) begin
            e.mant = '0;
            e.adj  = '0;
            e.sign = 1'b0;
            e.zero = 1'b1;
            e.lat  = 1;
            return e;
        end
        p = 0;
        for (int i = 0; i < W; i++) if (mag[i]) p = i;
        e.mant = mag << (W - 1 - p);
        e.adj  = AW'(-(W - 1 - p));
        e.lat  = W - p;
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge
    task automatic drive_op(input logic [W-1:0] sum, input logic cout, input logic sub);
        int t;
        bus.in_valid = 1'b1;
        bus.in_sum   = sum;
        bus.in_cout  = cout;
        bus.in_sub   = sub;
        t = 0;
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        sb.push_back(model(sum, cout, sub));
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_sum   = W'($urandom);
        bus.in_cout  = 1'($urandom);
        bus.in_sub   = 1'($urandom);
    endtask

    // Waits for out_valid, compares against the scoreboard, holds `hold` cycles, then takes it
    task automatic collect(input string tag, input int hold);
        int   n;
        exp_t e;
        logic [W+AW+2:0] snap;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus.out_valid) break;
        end
        if (!bus.out_valid) begin
            chk({tag, "_timeout"}, 64'd0, 64'd1);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_lat"},    64'(n),              64'(e.lat));
        chk({tag, "_mant"},   64'(bus.out_mant),   64'(e.mant));
        chk({tag, "_adj"},    64'(bus.out_adj),    64'(e.adj));
        chk({tag, "_sign"},   64'(bus.out_sign),   64'(e.sign));
        chk({tag, "_zero"},   64'(bus.out_zero),   64'(e.zero));
        chk({tag, "_sticky"}, 64'(bus.out_sticky), 64'(e.sticky));
        snap = {bus.out_mant, bus.out_adj, bus.out_sign, bus.out_zero, bus.out_sticky};
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_hold_out"},   64'({bus.out_mant, bus.out_adj, bus.out_sign, bus.out_zero, bus.out_sticky}), 64'(snap));
            chk({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
            chk({tag, "_hold_ready"}, 64'(bus.in_ready),  64'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_idle_ready"}, 64'(bus.in_ready),  64'd1);
        chk({tag, "_idle_valid"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        logic [W-1:0] s;
        bus.in_valid  = 1'b0;
        bus.in_sum    = '0;
        bus.in_cout   = 1'b0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_outs", 64'({bus.out_mant, bus.out_adj, bus.out_sign, bus.out_zero, bus.out_sticky}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases from the plan, with absolute expectations alongside the model
        drive_op(23'h000003, 1'b1, 1'b0);
        chk("ovf_exp_mant", 64'(sb[0].mant), 64'h400001);
        collect("ovf", 0);
        drive_op(23'h000001, 1'b1, 1'b0 ^ 1'b1);
        chk("one_exp_adj", 64'(sb[0].adj), 64'h2A);
        collect("one", 0);
        drive_op(23'h7FFFF0, 1'b0, 1'b1);
        chk("neg_exp_lat", 64'(sb[0].lat), 64'd19);
        collect("neg16", 0);
        drive_op(23'h000000, 1'b1, 1'b1);
        collect("zero", 0);
        drive_op(23'h400000, 1'b0, 1'b0);
        collect("norm", 0);
        drive_op(23'h400000, 1'b0, 1'b1);
        collect("negmin", 0);
        drive_op(23'h000000, 1'b0, 1'b1);
        collect("subzero_nc", 0);

        // Backpressure: a competing in_valid during DONE must not be taken
        drive_op(23'h000100, 1'b1, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_sum   = 23'h000005;
        bus.in_cout  = 1'b0;
        bus.in_sub   = 1'b0;
        collect("bp", 5);
        chk("bp_sb_empty", 64'(sb.size()), 64'd0);
        drive_op(23'h000010, 1'b0, 1'b0);
        collect("bp_next", 0);

        // Reset in the middle of a long normalization
        drive_op(23'h000001, 1'b1, 1'b1);
        void'(sb.pop_back());
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_ready", 64'(bus.in_ready),  64'd1);
        chk("mid_rst_outs", 64'({bus.out_mant, bus.out_adj, bus.out_sign, bus.out_zero, bus.out_sticky}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive_op(23'h400000, 1'b0, 1'b0);
        collect("post_rst", 0);

        // Random operands, including narrow magnitudes to exercise long shifts
        for (int i = 0; i < 24; i++) begin
            s = W'($urandom) >> $urandom_range(0, W - 1);
            drive_op(s, 1'($urandom), 1'($urandom));
            collect("rnd", 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
